// File: rtl/alu_pkg.sv
// Shared opcodes, shift-mode encodings and sequencer state for the ALU shift path.
// Pure declarations; no latency or flow control of its own.
package alu_pkg;

  localparam logic [1:0] LHS_OP_PASS = 2'b00;
  localparam logic [1:0] LHS_OP_SHL  = 2'b01;
  localparam logic [1:0] LHS_OP_SHR  = 2'b10;
  localparam logic [1:0] LHS_OP_ZERO = 2'b11;

  localparam logic [1:0] SHIFT_MODE_LOGICAL = 2'b00;
  localparam logic [1:0] SHIFT_MODE_RCT     = 2'b01;
  localparam logic [1:0] SHIFT_MODE_ROT     = 2'b10;
  localparam logic [1:0] SHIFT_MODE_ARITH   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } seq_state_e;

  // The bit entering the vacated position; only the operand's end bits matter.
  function automatic logic lhs_cin(input logic [1:0] mode, input logic dir,
                                   input logic val_msb, input logic val_lsb,
                                   input logic cy);
    logic cin;
    cin = 1'b0;
    case (mode)
      SHIFT_MODE_LOGICAL: cin = 1'b0;
      SHIFT_MODE_RCT:     cin = cy;
      SHIFT_MODE_ROT:     cin = dir ? val_lsb : val_msb;
      SHIFT_MODE_ARITH:   cin = dir ? val_msb : 1'b0;
      default:            cin = 1'b0;
    endcase
    return cin;
  endfunction

endpackage

// File: rtl/alu_shift_seq_if.sv
// Request/response and LHS-unit step signals between control sequencer, shift sequencer and LHS unit.
// Strobe/done pulses only; no backpressure beyond start being ignored while busy.
interface alu_shift_seq_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = $clog2(WIDTH) + 1
);
  logic               start;
  logic               dir;
  logic [1:0]         mode;
  logic [COUNT_W-1:0] count;
  logic [WIDTH-1:0]   value_in;
  logic               carry_init;

  logic               lhs_strobe;
  logic [1:0]         lhs_operation;
  logic [WIDTH-1:0]   lhs_in;
  logic               lhs_carry_in;
  logic [WIDTH-1:0]   lhs_out;
  logic               lhs_carry_out;

  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               carry_result;

  modport slave (
    input  start, dir, mode, count, value_in, carry_init,
    input  lhs_out, lhs_carry_out,
    output lhs_strobe, lhs_operation, lhs_in, lhs_carry_in,
    output busy, done, result, carry_result
  );

  modport master (
    output start, dir, mode, count, value_in, carry_init,
    output lhs_out, lhs_carry_out,
    input  lhs_strobe, lhs_operation, lhs_in, lhs_carry_in,
    input  busy, done, result, carry_result
  );
endinterface

// File: rtl/alu_shift_seq.sv
// Runs a multi-bit shift/rotate as max(count,1) one-bit LHS steps; done 2*max(count,1)+1 cycles after start.
// Start is ignored unless IDLE; no other backpressure.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = $clog2(WIDTH) + 1
) (
  input logic           clk,
  input logic           rst_n,
  alu_shift_seq_if.slave bus
);

  seq_state_e         state_q, state_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic               cy_q, cy_d;
  logic [COUNT_W-1:0] steps_q, steps_d;
  logic [1:0]         op_q, op_d;
  logic [1:0]         mode_q, mode_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_result_q, carry_result_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      val_q          <= '0;
      cy_q           <= 1'b0;
      steps_q        <= '0;
      op_q           <= LHS_OP_PASS;
      mode_q         <= SHIFT_MODE_LOGICAL;
      dir_q          <= 1'b0;
      result_q       <= '0;
      carry_result_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      val_q          <= val_d;
      cy_q           <= cy_d;
      steps_q        <= steps_d;
      op_q           <= op_d;
      mode_q         <= mode_d;
      dir_q          <= dir_d;
      result_q       <= result_d;
      carry_result_q <= carry_result_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    val_d          = val_q;
    cy_d           = cy_q;
    steps_d        = steps_q;
    op_d           = op_q;
    mode_d         = mode_q;
    dir_d          = dir_q;
    result_d       = result_q;
    carry_result_d = carry_result_q;

    bus.lhs_strobe    = 1'b0;
    bus.lhs_operation = LHS_OP_PASS;
    bus.lhs_in        = '0;
    bus.lhs_carry_in  = 1'b0;
    bus.done          = 1'b0;

    if (state_q != ST_IDLE) begin
      bus.lhs_operation = op_q;
      bus.lhs_in        = val_q;
      // Pass-through must return the captured carry unchanged, whatever the mode.
      bus.lhs_carry_in  = (op_q == LHS_OP_PASS) ? cy_q
                        : lhs_cin(mode_q, dir_q, val_q[WIDTH-1], val_q[0], cy_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          val_d   = bus.value_in;
          cy_d    = bus.carry_init;
          mode_d  = bus.mode;
          dir_d   = bus.dir;
          steps_d = (bus.count == '0) ? COUNT_W'(1) : bus.count;
          op_d    = (bus.count == '0) ? LHS_OP_PASS : (bus.dir ? LHS_OP_SHR : LHS_OP_SHL);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.lhs_strobe = 1'b1;
        state_d        = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        val_d   = bus.lhs_out;
        cy_d    = bus.lhs_carry_out;
        steps_d = steps_q - COUNT_W'(1);
        if (steps_q == COUNT_W'(1)) begin
          // Load the result here so it is already valid while done is high.
          result_d       = bus.lhs_out;
          carry_result_d = bus.lhs_carry_out;
          state_d        = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy         = (state_q == ST_ISSUE) || (state_q == ST_CAPTURE);
  assign bus.result       = result_q;
  assign bus.carry_result = carry_result_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed vectors for alu_shift_seq with a behavioural LHS unit; scoreboard monitor checks each done.
module tb_alu_shift_seq;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_shift_seq_if #(.WIDTH(W), .COUNT_W(CW)) bus ();
  alu_shift_seq #(.WIDTH(W), .COUNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // LHS unit: captures on the edge that ends the strobe, result valid next cycle.
  logic [W-1:0] lhs_o = '0;
  logic         lhs_c = 1'b0;
  always @(posedge clk) begin
    if (bus.lhs_strobe) begin
      case (bus.lhs_operation)
        2'b00: begin lhs_o <= bus.lhs_in; lhs_c <= bus.lhs_carry_in; end
        2'b01: begin lhs_o <= {bus.lhs_in[W-2:0], bus.lhs_carry_in}; lhs_c <= bus.lhs_in[W-1]; end
        2'b10: begin lhs_o <= {bus.lhs_carry_in, bus.lhs_in[W-1:1]}; lhs_c <= bus.lhs_in[0]; end
        default: begin lhs_o <= '0; lhs_c <= 1'b0; end
      endcase
    end
  end
  assign bus.lhs_out       = lhs_o;
  assign bus.lhs_carry_out = lhs_c;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       cy;
    int         done_cyc;
    int         strobes;
    int         base;
    logic [1:0] op;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  int   strobe_total = 0;
  logic [1:0] last_op = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endfunction

  // Monitor: counts strobes and checks each completion against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.lhs_strobe) begin
        strobe_total++;
        last_op = bus.lhs_operation;
      end
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk({e.name, ".result"}, 32'(bus.result), 32'(e.res));
          chk({e.name, ".carry"}, 32'(bus.carry_result), 32'(e.cy));
          chk({e.name, ".done_cycle"}, 32'(cyc), 32'(e.done_cyc));
          chk({e.name, ".strobes"}, 32'(strobe_total - e.base), 32'(e.strobes));
          chk({e.name, ".op"}, 32'(last_op), 32'(e.op));
        end
      end
    end
  end

  task automatic check_idle_outputs(string nm);
    chk({nm, ".busy"}, 32'(bus.busy), 32'd0);
    chk({nm, ".done"}, 32'(bus.done), 32'd0);
    chk({nm, ".result"}, 32'(bus.result), 32'd0);
    chk({nm, ".carry"}, 32'(bus.carry_result), 32'd0);
    chk({nm, ".strobe"}, 32'(bus.lhs_strobe), 32'd0);
    chk({nm, ".lhs_op"}, 32'(bus.lhs_operation), 32'd0);
    chk({nm, ".lhs_in"}, 32'(bus.lhs_in), 32'd0);
    chk({nm, ".lhs_cin"}, 32'(bus.lhs_carry_in), 32'd0);
  endtask

  task automatic run_vec(string nm, logic d, logic [1:0] m, logic [CW-1:0] cnt,
                         logic [7:0] v, logic ci, logic [7:0] xres, logic xcy,
                         logic [1:0] xop, bit poke);
    exp_t x;
    int   n;
    @(negedge clk);
    bus.dir = d; bus.mode = m; bus.count = cnt; bus.value_in = v; bus.carry_init = ci;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    n = (cnt == 0) ? 1 : int'(cnt);
    x.name = nm; x.res = xres; x.cy = xcy; x.op = xop;
    x.done_cyc = cyc + 2 * n;
    x.strobes = n;
    x.base = strobe_total;
    q.push_back(x);
    @(negedge clk);
    bus.start = 1'b0;
    if (poke) begin
      bus.start = 1'b1; bus.value_in = 8'h0F; bus.count = 4'd1; bus.dir = 1'b1;
      repeat (4) @(negedge clk);
      bus.start = 1'b0;
    end
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      chk({nm, ".timeout"}, 32'd1, 32'd0);
      q.delete();
    end
    @(negedge clk);
    chk({nm, ".busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int s;
    bus.start = 1'b0; bus.dir = 1'b0; bus.mode = 2'b00; bus.count = '0;
    bus.value_in = '0; bus.carry_init = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    //        name        dir   mode   cnt    value  cin   result carry  op     poke
    run_vec("lsl1",      1'b0, 2'b00, 4'd1, 8'h81, 1'b0, 8'h02, 1'b1, 2'b01, 1'b0);
    run_vec("ror1",      1'b1, 2'b10, 4'd1, 8'h01, 1'b0, 8'h80, 1'b1, 2'b10, 1'b0);
    run_vec("asr3",      1'b1, 2'b11, 4'd3, 8'h80, 1'b0, 8'hF0, 1'b0, 2'b10, 1'b0);
    run_vec("rcl2",      1'b0, 2'b01, 4'd2, 8'h80, 1'b0, 8'h01, 1'b0, 2'b01, 1'b0);
    run_vec("pass0",     1'b0, 2'b00, 4'd0, 8'h5A, 1'b1, 8'h5A, 1'b1, 2'b00, 1'b0);
    run_vec("lsr1_cin",  1'b1, 2'b00, 4'd1, 8'h01, 1'b1, 8'h00, 1'b1, 2'b10, 1'b0);
    run_vec("rcr1",      1'b1, 2'b01, 4'd1, 8'h01, 1'b1, 8'h80, 1'b1, 2'b10, 1'b0);
    run_vec("asl1",      1'b0, 2'b11, 4'd1, 8'h81, 1'b1, 8'h02, 1'b1, 2'b01, 1'b0);
    run_vec("rol4",      1'b0, 2'b10, 4'd4, 8'h81, 1'b0, 8'h18, 1'b0, 2'b01, 1'b0);
    run_vec("lsr9",      1'b1, 2'b00, 4'd9, 8'hFF, 1'b0, 8'h00, 1'b0, 2'b10, 1'b0);
    run_vec("lsl8_busy", 1'b0, 2'b00, 4'd8, 8'hFF, 1'b0, 8'h00, 1'b1, 2'b01, 1'b1);
    run_vec("asr1_last", 1'b1, 2'b11, 4'd1, 8'hC3, 1'b0, 8'hE1, 1'b1, 2'b10, 1'b0);

    // Abort a logical left count 8 during its second ISSUE cycle.
    @(negedge clk);
    bus.dir = 1'b0; bus.mode = 2'b00; bus.count = 4'd8; bus.value_in = 8'h81;
    bus.carry_init = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.second_issue", 32'(bus.lhs_strobe), 32'd1);
    chk("abort.cycle", 32'(cyc - s), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort.no_done_pending", 32'(q.size()), 32'd0);

    run_vec("after_abort", 1'b1, 2'b10, 4'd2, 8'h03, 1'b0, 8'hC0, 1'b1, 2'b10, 1'b0);

    repeat (5) @(negedge clk);
    chk("final.queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
